// File: rtl/bcd_multi_counter_scan.sv
// Up to three independent BCD counters sharing one 6-digit multiplexed 7-segment display.
// Optional feature macro: BLANK_LEADING_ZERO_EN (blank leading zeros within each channel).
module bcd_multi_counter_scan #(
  parameter int          DIG0     = 1,
  parameter int          DIG1     = 2,
  parameter int          DIG2     = 3,
  parameter logic [11:0] LIM0     = 12'h009,
  parameter logic [11:0] LIM1     = 12'h087,
  parameter logic [11:0] LIM2     = 12'h111,
  parameter logic [2:0]  DIR      = 3'b101,
  parameter logic [2:0]  WRAP     = 3'b111,
  parameter int          TICK_EXP = 21,
  parameter int          SCAN_EXP = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] enable,
  input  logic       clr,
  output logic [2:0] seg7_sel,
  output logic [6:0] seg7_out,
  output logic       dpt_out,
  output logic       led_com,
  output logic [2:0] carry
);

  localparam int P1 = DIG0;
  localparam int P2 = DIG0 + DIG1;
  localparam int P3 = DIG0 + DIG1 + DIG2;

  if (P3 > 6) begin : g_sum_err
    $error("bcd_multi_counter_scan: DIG0+DIG1+DIG2 exceeds 6");
  end

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Free-running dividers; tick and scan are single-cycle enables, never clocks.
  logic [TICK_EXP-1:0] tick_div_q, tick_div_d;
  logic [SCAN_EXP-1:0] scan_div_q, scan_div_d;
  logic [2:0]          sel_q, sel_d;
  logic                tick, scan;

  assign tick = &tick_div_q;
  assign scan = &scan_div_q;

  always_comb begin
    tick_div_d = tick_div_q + TICK_EXP'(1);
    scan_div_d = scan_div_q + SCAN_EXP'(1);
    sel_d      = sel_q;
    if (scan) begin
      sel_d = (sel_q == 3'd0) ? 3'd5 : sel_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_div_q <= '0;
      scan_div_q <= '0;
      sel_q      <= 3'd5;
    end else begin
      tick_div_q <= tick_div_d;
      scan_div_q <= scan_div_d;
      sel_q      <= sel_d;
    end
  end

  logic [11:0] cnt_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_ch
    localparam int          DIG_G = (g == 0) ? DIG0 : (g == 1) ? DIG1 : DIG2;
    localparam logic [11:0] LIM_G = (g == 0) ? LIM0 : (g == 1) ? LIM1 : LIM2;
    localparam logic [11:0] MASK  = (DIG_G >= 3) ? 12'hFFF : (DIG_G == 2) ? 12'h0FF : 12'h00F;
    localparam logic [11:0] LIM_M = LIM_G & MASK;
    // Wrapping always lands on the start value: 0 going up, LIM going down.
    localparam logic [11:0] START = DIR[g] ? 12'h000 : LIM_M;
    localparam logic [11:0] TERM  = DIR[g] ? LIM_M : 12'h000;
    localparam bit LIM_BAD = (LIM_G[3:0] > 4'd9) || (LIM_G[7:4] > 4'd9) || (LIM_G[11:8] > 4'd9);

    if (DIG_G < 1 || DIG_G > 3) begin : g_dig_err
      $error("bcd_multi_counter_scan: channel digit count out of range 1..3");
    end
    if (LIM_BAD) begin : g_lim_err
      $error("bcd_multi_counter_scan: channel terminal value is not valid BCD");
    end

    logic [11:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = START;
      end else if (tick && enable[g]) begin
        if (cnt_q == TERM) begin
          cnt_d = WRAP[g] ? START : cnt_q;
        end else if (DIR[g]) begin
          cnt_d = bcd_inc(cnt_q) & MASK;
        end else begin
          cnt_d = bcd_dec(cnt_q) & MASK;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= START;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_w[g] = cnt_q;
    assign carry[g] = (cnt_q == TERM);
  end

  // Map the scan position onto a channel and a digit index counted from its LSD.
  int          sel_int;
  int          dig_idx;
  logic        ch_valid;
  logic [11:0] ch_cnt;
  logic [11:0] ch_shift;

  always_comb begin
    sel_int  = {29'd0, sel_q};
    ch_valid = 1'b1;
    ch_cnt   = 12'h000;
    dig_idx  = 0;
    if (sel_int < P1) begin
      ch_cnt  = cnt_w[0];
      dig_idx = P1 - 1 - sel_int;
    end else if (sel_int < P2) begin
      ch_cnt  = cnt_w[1];
      dig_idx = P2 - 1 - sel_int;
    end else if (sel_int < P3) begin
      ch_cnt  = cnt_w[2];
      dig_idx = P3 - 1 - sel_int;
    end else begin
      ch_valid = 1'b0;
    end
    ch_shift = ch_cnt >> (4 * dig_idx);
    seg7_out = ch_valid ? seg_decode(ch_shift[3:0]) : 7'b0000000;
`ifdef BLANK_LEADING_ZERO_EN
    if (dig_idx != 0 && ch_shift == 12'h000) begin
      seg7_out = 7'b0000000;
    end
`endif
    dpt_out = ch_valid && (dig_idx == 0);
  end

  assign seg7_sel = sel_q;
  assign led_com  = 1'b1;

endmodule
